// File: rtl/aes_cipher_iter.sv
// Iterative AES encrypt core, one round per clk, Nk = 4/6/8 selects AES-128/192/256.
// Latency: out_valid rises Nr edges after accept; result held until out_ready, in_ready only in IDLE.
// Define AES_CIPHER_ROUND_MON_EN to expose round_mon / round_strobe.
module aes_cipher_iter #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           in_data,
    input  logic [0:(Nr+1)*128-1]  in_keys,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           out_data,
    output logic                   busy
`ifdef AES_CIPHER_ROUND_MON_EN
    ,
    output logic [3:0]             round_mon,
    output logic                   round_strobe
`endif
);

    if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6) begin : g_bad_param
        $error("aes_cipher_iter: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
    end

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_HOLD} state_t;

    state_t                  state;
    logic [3:0]              rnd;
    logic [127:0]            st;
    logic [0:(Nr+1)*128-1]   key_reg;
    logic [127:0]            round_out;
    logic [127:0]            final_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = '0;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (x^254, 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte 0 is the MSB; state is column-major, byte index 4*col + row
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    assign round_out = add_round_key(mix_columns(shift_rows(sub_bytes(st))), key_reg[128*int'(rnd) +: 128]);
    assign final_out = add_round_key(shift_rows(sub_bytes(st)), key_reg[128*Nr +: 128]);

`ifdef AES_CIPHER_ROUND_MON_EN
    assign round_mon = rnd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rnd       <= '0;
            st        <= '0;
            key_reg   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef AES_CIPHER_ROUND_MON_EN
            round_strobe <= 1'b0;
`endif
        end else begin
`ifdef AES_CIPHER_ROUND_MON_EN
            round_strobe <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= add_round_key(in_data, in_keys[0 +: 128]);
                        key_reg  <= in_keys;
                        rnd      <= 4'd1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    // rnd ends at Nr so FINAL/HOLD report the last round number
                    st  <= round_out;
                    rnd <= rnd + 4'd1;
`ifdef AES_CIPHER_ROUND_MON_EN
                    round_strobe <= 1'b1;
`endif
                    if (rnd == 4'(Nr - 1)) state <= S_FINAL;
                end
                S_FINAL: begin
                    out_data  <= final_out;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        rnd       <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: FIPS-197 / SP800-38A known answers on Nk=4/6/8 instances,
// plus backpressure, input-stability, mid-block reset and back-to-back sequences on the Nk=4 core.
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic                in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0]        in_data, out_data;
    logic [0:1407]       in_keys;
    logic                in_valid6, in_ready6, out_valid6, out_ready6, busy6;
    logic [127:0]        in_data6, out_data6;
    logic [0:1663]       in_keys6;
    logic                in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [127:0]        in_data8, out_data8;
    logic [0:1919]       in_keys8;
`ifdef AES_CIPHER_ROUND_MON_EN
    logic [3:0] round_mon, round_mon6, round_mon8;
    logic       round_strobe, round_strobe6, round_strobe8;
`endif

    aes_cipher_iter #(.Nk(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keys(in_keys), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef AES_CIPHER_ROUND_MON_EN
        , .round_mon(round_mon), .round_strobe(round_strobe)
`endif
    );

    aes_cipher_iter #(.Nk(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_data(in_data6), .in_keys(in_keys6), .out_valid(out_valid6),
        .out_ready(out_ready6), .out_data(out_data6), .busy(busy6)
`ifdef AES_CIPHER_ROUND_MON_EN
        , .round_mon(round_mon6), .round_strobe(round_strobe6)
`endif
    );

    aes_cipher_iter #(.Nk(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_keys(in_keys8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_data(out_data8), .busy(busy8)
`ifdef AES_CIPHER_ROUND_MON_EN
        , .round_mon(round_mon8), .round_strobe(round_strobe8)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Key expansion model, used only to build round-key schedules
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = '0;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sb_model(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_model(w[31:24]), sb_model(w[23:16]), sb_model(w[15:8]), sb_model(w[7:0])};
    endfunction

    function automatic logic [0:1919] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] ks;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            ks[32*i +: 32] = w[i];
        end
        return ks;
    endfunction

    // Scoreboard for the Nk=4 core: push at accept, check latency at rise and data at handshake
    typedef struct { logic [127:0] ct; int acc; } exp_t;
    exp_t         sb[$];
    logic [127:0] cur_ct = '0;
    logic         ov_q = 1'b0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            sb.delete();
            ov_q = 1'b0;
        end else begin
            if (in_valid && in_ready) sb.push_back('{cur_ct, cyc + 1});
            if (out_valid && !ov_q) begin
                if (sb.size() == 0) timeout("unexpected_out_valid");
                else check("latency", 128'(cyc - sb[0].acc), 128'd10);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) timeout("unexpected_handshake");
                else check("ciphertext", out_data, sb.pop_front().ct);
            end
            ov_q = out_valid;
        end
    end

    // Called at posedge+#1; returns the accept edge number
    task automatic send(input logic [127:0] pt, input logic [0:1407] ks, input logic [127:0] ct, output int acc);
        int n = 0;
        in_data  = pt;
        in_keys  = ks;
        cur_ct   = ct;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) timeout("send_in_ready");
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 128'(sb.size()), 128'd0);
    endtask

    task automatic kat_wide(input int idx, input int nk, input logic [0:1919] ks,
                            input logic [127:0] pt, input logic [127:0] ct);
        int   lat = 0;
        logic ov;
        if (nk == 6) begin
            check($sformatf("kat%0d_in_ready", idx), 128'(in_ready6), 128'd1);
            in_data6 = pt; in_keys6 = ks[0 +: 1664]; in_valid6 = 1'b1;
        end else begin
            check($sformatf("kat%0d_in_ready", idx), 128'(in_ready8), 128'd1);
            in_data8 = pt; in_keys8 = ks; in_valid8 = 1'b1;
        end
        @(posedge clk); #1;
        in_valid6 = 1'b0;
        in_valid8 = 1'b0;
        ov = (nk == 6) ? out_valid6 : out_valid8;
        while (!ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            ov = (nk == 6) ? out_valid6 : out_valid8;
        end
        check($sformatf("kat%0d_latency", idx), 128'(lat), 128'(nk + 6));
        check($sformatf("kat%0d_ct", idx), (nk == 6) ? out_data6 : out_data8, ct);
        @(posedge clk); #1;
    endtask

    typedef struct { int nk; logic [255:0] key; logic [127:0] pt; logic [127:0] ct; } tv_t;
    tv_t tv [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            a0, a1, a2, n;
        logic [0:1919] ks;
        logic [127:0]  pt0, ct0;

        tv[0] = '{4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tv[1] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        tv[2] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        tv[3] = '{6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                  128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        tv[4] = '{8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
        tv[5] = '{8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  128'h6bc1bee22e409f96e93d7e117393172a, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8};

        in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_keys = '0;
        in_valid6 = 1'b0; out_ready6 = 1'b1; in_data6 = '0; in_keys6 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; in_data8 = '0; in_keys8 = '0;

        #12;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            ks = expand(tv[i].key, tv[i].nk);
            if (tv[i].nk == 4) begin
                send(tv[i].pt, ks[0 +: 1408], tv[i].ct, a0);
                in_valid = 1'b0;
                wait_drain($sformatf("kat%0d_drain", i));
            end else begin
                kat_wide(i, tv[i].nk, ks, tv[i].pt, tv[i].ct);
            end
        end

        pt0 = tv[0].pt;
        ct0 = tv[0].ct;
        ks  = expand(tv[0].key, 4);

        // Backpressure: result must hold while out_ready is low; in_valid is ignored meanwhile
        out_ready = 1'b0;
        send(pt0, ks[0 +: 1408], ct0, a0);
        cur_ct = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) timeout("bp_wait_out_valid");
        for (int k = 0; k < 20; k++) begin
            check("bp_out_data", out_data, ct0);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_in_ready", 128'(in_ready), 128'd1);
        check("bp_idle_out_valid", 128'(out_valid), 128'd0);
        check("bp_idle_busy", 128'(busy), 128'd0);
        check("bp_idle_out_data", out_data, ct0);
        check("bp_drain", 128'(sb.size()), 128'd0);

        // Input stability: scramble inputs every cycle while the block is in flight
        out_ready = 1'b0;
        send(pt0, ks[0 +: 1408], ct0, a0);
        n = 0;
        while (!out_valid && n < 40) begin
            cur_ct  = 128'hbad1bad1bad1bad1bad1bad1bad1bad1;
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int w = 0; w < 44; w++) in_keys[32*w +: 32] = $urandom();
            in_valid = 1'b1;
            check("stab_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) timeout("stab_wait_out_valid");
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain("stab_drain");

        // Mid-block reset during the 5th ROUND cycle
        send(tv[1].pt, expand(tv[1].key, 4)[0 +: 1408], tv[1].ct, a0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mrst_out_valid", 128'(out_valid), 128'd0);
        check("mrst_out_data", out_data, 128'd0);
        check("mrst_in_ready", 128'(in_ready), 128'd1);
        check("mrst_busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(tv[2].pt, expand(tv[2].key, 4)[0 +: 1408], tv[2].ct, a0);
        in_valid = 1'b0;
        wait_drain("mrst_fresh_drain");

        // Back-to-back with in_valid and out_ready held high
        send(tv[0].pt, ks[0 +: 1408], tv[0].ct, a0);
        send(tv[1].pt, expand(tv[1].key, 4)[0 +: 1408], tv[1].ct, a1);
        send(tv[2].pt, expand(tv[2].key, 4)[0 +: 1408], tv[2].ct, a2);
        in_valid = 1'b0;
        wait_drain("b2b_drain");
        check("b2b_gap1", 128'(a1 - a0), 128'd12);
        check("b2b_gap2", 128'(a2 - a1), 128'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
